// File: rtl/venc_frame_ctrl_if.sv
// Signal bundle between the frame sequencer and its neighbours: the upstream
// bit source, the convolutional encoder datapath and the downstream symbol sink.
interface venc_frame_ctrl_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic enc_in;
  logic enc_shift;
  logic enc_clear;
  logic enc_g0;
  logic enc_g1;
  logic out_valid;
  logic out_bit;
  logic out_last;
  logic out_ready;

  // Controller side
  modport master (
    input  in_valid, in_bit, enc_g0, enc_g1, out_ready,
    output in_ready, enc_in, enc_shift, enc_clear, out_valid, out_bit, out_last
  );

  // Environment side: source, encoder and sink
  modport slave (
    output in_valid, in_bit, enc_g0, enc_g1, out_ready,
    input  in_ready, enc_in, enc_shift, enc_clear, out_valid, out_bit, out_last
  );
endinterface

// File: rtl/venc_frame_ctrl.sv
// Frame sequencer for the rate-1/2 convolutional encoder on the PRML write path.
// Clears the encoder, takes FRAME_LEN data bits one at a time, appends K-1 zero
// tail bits and serialises every (g0,g1) pair into a 1-bit symbol stream.
module venc_frame_ctrl #(
  parameter int FRAME_LEN = 8,
  parameter int K         = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  venc_frame_ctrl_if.master bus,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(FRAME_LEN + K) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(FRAME_LEN + K - 2);
  localparam logic [CNT_W-1:0] DATA_STEPS = CNT_W'(FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    SYM0,
    SYM1,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [CNT_W-1:0] cntInc;
  logic             hold_q, hold_d;

  // State, step counter and held encoder input bit
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      hold_q   <= hold_d;
    end
  end

  // Next state and all outputs; outputs are forced low while reset is held so an abort emits nothing further
  always_comb begin
    state_d       = state_q;
    bitCnt_d      = bitCnt_q;
    hold_d        = hold_q;
    cntInc        = bitCnt_q + CNT_W'(1);
    bus.in_ready  = 1'b0;
    bus.enc_in    = 1'b0;
    bus.enc_shift = 1'b0;
    bus.enc_clear = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_bit   = 1'b0;
    bus.out_last  = 1'b0;
    busy_o        = (state_q != IDLE);
    done_o        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) state_d = CLEAR;
      end
      CLEAR: begin
        bus.enc_clear = 1'b1;
        bitCnt_d      = '0;
        state_d       = LOAD;
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          hold_d  = bus.in_bit;
          state_d = SYM0;
        end
      end
      SYM0: begin
        bus.enc_in    = hold_q;
        bus.out_valid = 1'b1;
        bus.out_bit   = bus.enc_g0;
        if (bus.out_ready) state_d = SYM1;
      end
      SYM1: begin
        bus.enc_in    = hold_q;
        bus.out_valid = 1'b1;
        bus.out_bit   = bus.enc_g1;
        bus.out_last  = (bitCnt_q == LAST_STEP);
        if (bus.out_ready) begin
          bus.enc_shift = 1'b1;
          bitCnt_d      = cntInc;
          if (bitCnt_q == LAST_STEP) begin
            state_d = DONE;
          end else if (cntInc < DATA_STEPS) begin
            state_d = LOAD;
          end else begin
            hold_d  = 1'b0;
            state_d = SYM0;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      bus.in_ready  = 1'b0;
      bus.enc_in    = 1'b0;
      bus.enc_shift = 1'b0;
      bus.enc_clear = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_bit   = 1'b0;
      bus.out_last  = 1'b0;
      busy_o        = 1'b0;
      done_o        = 1'b0;
    end
  end

endmodule

// File: tb/tb_venc_frame_ctrl.sv
// Bench for the encoder frame sequencer: a small encoder model supplies g0/g1,
// the expected symbol stream is derived from the convolution rules directly.
module tb_venc_frame_ctrl;

  localparam int FRAME_LEN = 4;
  localparam int K         = 3;
  localparam int NSTEP     = FRAME_LEN + K - 1;
  localparam int NSYM      = 2 * NSTEP;
  localparam int BASE_LAT  = 1 + 3 * FRAME_LEN + 2 * (K - 1) + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  venc_frame_ctrl_if bus ();

  venc_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .K(K)) dut (
    .clock   (clock),
    .reset   (reset),
    .start_i (start),
    .bus     (bus.master),
    .busy_o  (busy),
    .done_o  (done)
  );

  // Free-running system clock
  always #5 clock = ~clock;

  // Encoder datapath model, deliberately starting in a non-zero state
  logic s0 = 1'b1;
  logic s1 = 1'b1;
  assign bus.enc_g0 = bus.enc_in ^ s0 ^ s1;
  assign bus.enc_g1 = bus.enc_in ^ s0;

  // Encoder shift register: cleared or advanced by the controller
  always @(posedge clock) begin
    if (bus.enc_clear) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else if (bus.enc_shift) begin
      s1 <= s0;
      s0 <= bus.enc_in;
    end
  end

  int checks = 0;
  int errors = 0;

  int cycCnt = 0, startCyc = 0, doneCyc = 0, doneCnt = 0, clearCnt = 0;
  int shiftCnt = 0, inReadyCnt = 0, symCnt = 0, bitsAccepted = 0;
  logic [NSYM-1:0] gotStream = '0;
  logic expSym [NSYM];
  logic frameData [FRAME_LEN];

  int resetReq = 0, startReq = 0;
  int readyStallSym = -1, readyStallLen = 0, readyStallCnt = 0;
  int validStallBit = -1, validStallLen = 0, validStallCnt = 0;
  int startPulseSym = -1, resetAtSym = -1;
  bit startAtDone = 1'b0, resetFired = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycCnt);
    end
  endtask

  function automatic logic dataAt(input int j);
    if (j < 0 || j >= FRAME_LEN) return 1'b0;
    return frameData[j];
  endfunction

  // Rate-1/2 code from its definition: g0 = u[j]^u[j-1]^u[j-2], g1 = u[j]^u[j-1]
  task automatic buildExpected();
    for (int j = 0; j < NSTEP; j++) begin
      expSym[2*j]     = dataAt(j) ^ dataAt(j-1) ^ dataAt(j-2);
      expSym[2*j + 1] = dataAt(j) ^ dataAt(j-1);
    end
  endtask

  function automatic logic [NSYM-1:0] packExp();
    logic [NSYM-1:0] r = '0;
    for (int i = 0; i < NSYM; i++) r = {r[NSYM-2:0], expSym[i]};
    return r;
  endfunction

  task automatic setData(input logic b0, input logic b1, input logic b2, input logic b3);
    frameData[0] = b0;
    frameData[1] = b1;
    frameData[2] = b2;
    frameData[3] = b3;
  endtask

  // Drives every DUT input shortly after each rising edge
  task automatic driverLoop();
    forever begin
      @(posedge clock);
      #1;
      cycCnt++;
      reset = 1'b0;
      start = 1'b0;
      if (resetReq > 0) begin
        reset = 1'b1;
        resetReq--;
      end
      if (resetAtSym >= 0 && bus.out_valid && symCnt == resetAtSym) begin
        reset      = 1'b1;
        resetAtSym = -1;
        resetFired = 1'b1;
      end
      if (startReq != 0) begin
        start         = 1'b1;
        startReq      = 0;
        startCyc      = cycCnt;
        readyStallCnt = 0;
        validStallCnt = 0;
      end
      if (startPulseSym >= 0 && bus.out_valid && symCnt == startPulseSym) begin
        start         = 1'b1;
        startPulseSym = -1;
      end
      if (startAtDone && done) begin
        start       = 1'b1;
        startAtDone = 1'b0;
      end
      bus.in_valid = 1'b1;
      if (bus.in_ready && bitsAccepted == validStallBit && validStallCnt < validStallLen) begin
        bus.in_valid = 1'b0;
        validStallCnt++;
      end
      bus.in_bit    = dataAt(bitsAccepted);
      bus.out_ready = 1'b1;
      if (bus.out_valid && symCnt == readyStallSym && readyStallCnt < readyStallLen) begin
        bus.out_ready = 1'b0;
        readyStallCnt++;
      end
    end
  endtask

  // Compares DUT outputs against the model on every falling edge
  task automatic monitorLoop();
    logic prevStall = 1'b0;
    logic prevBit   = 1'b0;
    logic prevEncIn = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prevStall = 1'b0;
        continue;
      end
      checkOutput("enc_shift", bus.enc_shift,
                  bus.out_valid && bus.out_ready && (symCnt % 2 == 1));
      checkOutput("in_ready_and_out_valid", bus.in_ready & bus.out_valid, 1'b0);
      if (bus.out_valid || bus.in_ready || bus.enc_clear) checkOutput("busy", busy, 1'b1);
      if (prevStall) begin
        checkOutput("stall_valid", bus.out_valid, 1'b1);
        checkOutput("stall_bit", bus.out_bit, prevBit);
        checkOutput("stall_enc_in", bus.enc_in, prevEncIn);
      end
      if (bus.enc_clear) begin
        clearCnt++;
        symCnt       = 0;
        bitsAccepted = 0;
        shiftCnt     = 0;
        inReadyCnt   = 0;
        gotStream    = '0;
      end
      if (bus.in_ready) inReadyCnt++;
      if (bus.in_ready && bus.in_valid) bitsAccepted++;
      if (bus.enc_shift) shiftCnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (symCnt < NSYM) begin
          checkOutput("symbol", bus.out_bit, expSym[symCnt]);
          checkOutput("out_last", bus.out_last, symCnt == NSYM - 1);
        end else begin
          checkOutput("extra_symbol", symCnt, NSYM - 1);
        end
        gotStream = {gotStream[NSYM-2:0], bus.out_bit};
        symCnt++;
      end
      if (done) begin
        doneCnt++;
        doneCyc = cycCnt;
      end
      prevStall = bus.out_valid && !bus.out_ready;
      prevBit   = bus.out_bit;
      prevEncIn = bus.enc_in;
    end
  endtask

  // Runs one complete frame and checks its totals against hand-computed values
  task automatic applyStimulus(input string tag, input logic [NSYM-1:0] litStream,
                               input int extraLat, input int extraInReady);
    int doneBase;
    int clearBase;
    buildExpected();
    checkOutput({tag, " model"}, packExp(), litStream);
    doneBase  = doneCnt;
    clearBase = clearCnt;
    startReq  = 1;
    for (int i = 0; i < 400 && doneCnt == doneBase; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    checkOutput({tag, " done_count"}, doneCnt - doneBase, 1);
    checkOutput({tag, " latency"}, doneCyc - startCyc, BASE_LAT + extraLat);
    checkOutput({tag, " stream"}, gotStream, litStream);
    checkOutput({tag, " symbols"}, symCnt, NSYM);
    checkOutput({tag, " shifts"}, shiftCnt, NSTEP);
    checkOutput({tag, " clears"}, clearCnt - clearBase, 1);
    checkOutput({tag, " in_ready_cycles"}, inReadyCnt, FRAME_LEN + extraInReady);
    checkOutput({tag, " idle_after"}, busy, 1'b0);
  endtask

  // Directed sequence of scenarios
  initial begin
    int doneBase;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    resetReq      = 2;
    fork
      driverLoop();
      monitorLoop();
      begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    // Reset and idle with start low
    repeat (2) @(negedge clock);
    checkOutput("reset_outputs",
                {busy, done, bus.in_ready, bus.enc_shift, bus.enc_clear,
                 bus.out_valid, bus.out_last, bus.out_bit, bus.enc_in}, '0);
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("idle_outputs",
                  {busy, done, bus.in_ready, bus.enc_clear, bus.out_valid}, '0);
    end
    @(posedge clock);

    // Basic frame 1,0,1,1
    setData(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus("basic", 12'b1111_0100_0110, 0, 0);

    // Downstream backpressure on the g1 symbol of the second bit
    readyStallSym = 3;
    readyStallLen = 5;
    applyStimulus("ready_stall", 12'b1111_0100_0110, 5, 0);
    readyStallSym = -1;
    readyStallLen = 0;

    // Upstream gap before the third data bit
    validStallBit = 2;
    validStallLen = 3;
    applyStimulus("valid_stall", 12'b1111_0100_0110, 3, 3);
    validStallBit = -1;
    validStallLen = 0;

    // Start pulse in the middle of a frame is ignored
    startPulseSym = 2;
    applyStimulus("start_ignored", 12'b1111_0100_0110, 0, 0);
    startPulseSym = -1;

    // Reset during the g1 symbol of the last data bit aborts the frame
    doneBase   = doneCnt;
    resetFired = 1'b0;
    resetAtSym = 7;
    startReq   = 1;
    for (int i = 0; i < 100 && !resetFired; i++) @(posedge clock);
    checkOutput("abort_reset_fired", resetFired, 1'b1);
    @(negedge clock);
    checkOutput("abort_idle", {busy, bus.out_valid, bus.in_ready}, '0);
    repeat (10) @(posedge clock);
    checkOutput("abort_no_done", doneCnt - doneBase, 0);
    checkOutput("abort_symbols", symCnt, 7);
    resetAtSym = -1;

    // New frame after the abort must be identical (encoder re-cleared)
    applyStimulus("after_abort", 12'b1111_0100_0110, 0, 0);

    // All-zero frame; start raised in the DONE cycle must not restart
    setData(1'b0, 1'b0, 1'b0, 1'b0);
    startAtDone = 1'b1;
    applyStimulus("zeros", 12'b0000_0000_0000, 0, 0);
    checkOutput("start_in_done_consumed", startAtDone, 1'b0);
    startAtDone = 1'b0;

    // Start issued in the following IDLE begins a normal frame
    setData(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus("back_to_back", 12'b1111_0100_0110, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
